cue_controller: RTL and testbench
=================================

CUE_CONTROLLER -- requirements
Module: cue_controller

Interface
REQ-001 SHALL have parameters: OBJECT_RADIUS=16 (ball radius, px); CUE_LENGTH=128 (cue length, px); GAP=4 (ball-to-tip gap, px); MAX_PULL=64 (max pull-back, px); CHARGE_STEP=1 (pull increment per frame); STRIKE_STEP=8 (forward travel per frame); ROT_DIV=4 (frames per rotation step).
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  system clock, single domain
  reset  in  1  synchronous, active-high reset
  startOfFrame  in  1  one-cycle pulse per VGA frame; frame tick
  ballX, ballY  in  int  cue-ball centre, screen px
  balls_moving  in  1  any ball in motion
  rotate_left, rotate_right  in  1  level, aim rotate keys
  charge  in  1  level, charge key held
  closeEdgeX, closeEdgeY  out  int  cue tip, to cue_object
  farEdgeX, farEdgeY  out  int  cue butt, to cue_object
  cue_enable  out  1  cue visible
  shot_valid  out  1  one-cycle shot strobe
  shot_vx, shot_vy  out  int  signed shot velocity, valid with shot_valid
  power  out  7  current pull, 0..MAX_PULL

Function
REQ-003 SHALL hold aim index dir (5 bits, 32 directions); LUT gives signed (cosK, sinK) = round(64*cos(2*pi*dir/32)), round(64*sin(2*pi*dir/32)), +Y = screen down; dir 0=(64,0), 8=(0,64), 16=(-64,0), 24=(0,-64).
REQ-004 SHALL implement FSM states IDLE, AIM, CHARGE, STRIKE, FIRE.
REQ-005 IDLE: cue_enable=0, pull=0; -> AIM on first startOfFrame with balls_moving=0.
REQ-006 AIM: cue_enable=1; -> CHARGE on startOfFrame with charge=1; -> IDLE any cycle balls_moving=1.
REQ-007 Rotation only in AIM, evaluated on startOfFrame: exactly one key held -> rot_cnt++; at rot_cnt==ROT_DIV-1 -> dir +1 (right) / -1 (left) mod 32, rot_cnt=0; none or both held -> rot_cnt=0, dir unchanged.
REQ-008 dir wraps 31->0 (right) and 0->31 (left).
REQ-009 CHARGE: each startOfFrame with charge=1 -> pull = min(pull+CHARGE_STEP, MAX_PULL) (saturating); charge=0 with pull>0 -> latch shot_pull=pull, -> STRIKE; charge=0 with pull=0 -> AIM, no shot; balls_moving=1 -> IDLE, pull=0.
REQ-010 STRIKE: each startOfFrame pull = max(pull-STRIKE_STEP, 0); when pull reaches 0 -> FIRE; keys and balls_moving ignored.
REQ-011 FIRE: shot_valid=1 for exactly one clk; shot_vx=(cosK*shot_pull)>>>6, shot_vy=(sinK*shot_pull)>>>6 (arithmetic shift); next cycle -> IDLE, cue_enable=0.
REQ-012 Geometry: d=OBJECT_RADIUS+GAP+pull; closeEdgeX=ballX-((cosK*d)>>>6), closeEdgeY=ballY-((sinK*d)>>>6); farEdgeX=closeEdgeX-((cosK*CUE_LENGTH)>>>6), farEdgeY=closeEdgeY-((sinK*CUE_LENGTH)>>>6); all products 32-bit signed.
REQ-013 Edge outputs, cue_enable, power SHALL be registered, updated one clk after any change of state, dir, pull, ballX/ballY.
REQ-014 shot_vx/shot_vy SHALL hold their last value outside FIRE; only shot_valid qualifies them.
REQ-015 power SHALL equal pull; 0 in IDLE.
REQ-016 startOfFrame and a state-changing input in the same cycle: the transition rule of the current state applies once; no double step per frame.

Reset
REQ-017 reset=1 at any clk edge, including mid-CHARGE/STRIKE: state=IDLE, dir=0, pull=0, shot_pull=0, rot_cnt=0, cue_enable=0, shot_valid=0, shot_vx=shot_vy=0, all edge outputs=0, power=0; the aborted shot SHALL NOT fire.

Verification
REQ-018 Reset, balls_moving=0, ball (320,240), one frame -> AIM, cue_enable=1, close=(300,240), far=(172,240).
REQ-019 rotate_right held 4 frames from dir 0 -> dir=1 after 4th frame only; rotate_left at dir 0 for 4 frames -> dir=31; both held 8 frames -> dir unchanged.
REQ-020 dir 0, charge held 70 frames -> power saturates at 64, close=(236,240), far=(108,240).
REQ-021 release charge at pull=64 -> STRIKE lasts 8 frames, then single-cycle shot_valid with shot_vx=64, shot_vy=0, next cycle IDLE, cue_enable=0; dir=8 same sequence -> shot_vx=0, shot_vy=64.
REQ-022 charge pressed and released with pull=0 -> back to AIM, no shot_valid; balls_moving=1 during CHARGE -> IDLE, power=0, no shot.
REQ-023 reset asserted during STRIKE -> next cycle all outputs at reset values, no shot_valid afterwards.

Source files
------------

// File: rtl/cue_controller.sv
// cue_controller: aim, charge and strike FSM for the pool cue, with registered cue geometry and shot velocity.
module cue_controller #(
    parameter int OBJECT_RADIUS = 16,
    parameter int CUE_LENGTH    = 128,
    parameter int GAP           = 4,
    parameter int MAX_PULL      = 64,
    parameter int CHARGE_STEP   = 1,
    parameter int STRIKE_STEP   = 8,
    parameter int ROT_DIV       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic signed [31:0] ballX,
    input  logic signed [31:0] ballY,
    input  logic               balls_moving,
    input  logic               rotate_left,
    input  logic               rotate_right,
    input  logic               charge,
    output logic signed [31:0] closeEdgeX,
    output logic signed [31:0] closeEdgeY,
    output logic signed [31:0] farEdgeX,
    output logic signed [31:0] farEdgeY,
    output logic               cue_enable,
    output logic               shot_valid,
    output logic signed [31:0] shot_vx,
    output logic signed [31:0] shot_vy,
    output logic [6:0]         power
);
    typedef enum logic [2:0] {IDLE, AIM, CHARGE, STRIKE, FIRE} state_t;
    localparam logic [7:0] ROT_LAST = 8'(ROT_DIV - 1);
    state_t      r_state;
    logic [4:0]  r_dir;
    logic [6:0]  r_pull, r_shot_pull;
    logic [7:0]  r_rot;
    logic [7:0]  w_inc;
    logic [6:0]  w_chg, w_dec;
    logic        w_one_key;
    logic signed [31:0] w_cos, w_sin, w_d, w_sp, w_cx, w_cy;
    function automatic logic signed [31:0] lut(input logic [4:0] k);
        logic [3:0] a, m;
        logic signed [31:0] q, b;
        a = k[3:0];
        m = a <= 4'd8 ? a : 4'(5'd16 - {1'b0, a});
        case (m)
            4'd0:    q = 64;
            4'd1:    q = 63;
            4'd2:    q = 59;
            4'd3:    q = 53;
            4'd4:    q = 45;
            4'd5:    q = 36;
            4'd6:    q = 24;
            4'd7:    q = 12;
            default: q = 0;
        endcase
        b = a <= 4'd8 ? q : -q;
        return k[4] ? -b : b;
    endfunction
    assign w_cos     = lut(r_dir);
    assign w_sin     = lut(r_dir - 5'd8);
    assign w_d       = 32'(OBJECT_RADIUS + GAP) + 32'(r_pull);
    assign w_sp      = 32'(r_shot_pull);
    assign w_cx      = ballX - ((w_cos * w_d) >>> 6);
    assign w_cy      = ballY - ((w_sin * w_d) >>> 6);
    assign w_inc     = {1'b0, r_pull} + 8'(CHARGE_STEP);
    assign w_chg     = w_inc > 8'(MAX_PULL) ? 7'(MAX_PULL) : w_inc[6:0];
    assign w_dec     = r_pull > 7'(STRIKE_STEP) ? r_pull - 7'(STRIKE_STEP) : 7'd0;
    assign w_one_key = rotate_left ^ rotate_right;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dir       <= '0;
            r_pull      <= '0;
            r_shot_pull <= '0;
            r_rot       <= '0;
            cue_enable  <= 1'b0;
            shot_valid  <= 1'b0;
            shot_vx     <= '0;
            shot_vy     <= '0;
            closeEdgeX  <= '0;
            closeEdgeY  <= '0;
            farEdgeX    <= '0;
            farEdgeY    <= '0;
            power       <= '0;
        end else begin
            closeEdgeX <= w_cx;
            closeEdgeY <= w_cy;
            farEdgeX   <= w_cx - ((w_cos * CUE_LENGTH) >>> 6);
            farEdgeY   <= w_cy - ((w_sin * CUE_LENGTH) >>> 6);
            power      <= r_pull;
            cue_enable <= r_state inside {AIM, CHARGE, STRIKE};
            shot_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pull <= '0;
                    r_rot  <= '0;
                    if (startOfFrame && !balls_moving) r_state <= AIM;
                end
                AIM: begin
                    if (balls_moving) r_state <= IDLE;
                    else if (startOfFrame) begin
                        r_state <= charge ? CHARGE : AIM;
                        r_rot   <= w_one_key && r_rot != ROT_LAST ? r_rot + 8'd1 : 8'd0;
                        if (w_one_key && r_rot == ROT_LAST) r_dir <= rotate_right ? r_dir + 5'd1 : r_dir - 5'd1;
                    end
                end
                CHARGE: begin
                    if (balls_moving) begin
                        r_state <= IDLE;
                        r_pull  <= '0;
                    end else if (startOfFrame) begin
                        if (charge) r_pull <= w_chg;
                        else begin
                            r_shot_pull <= r_pull;
                            r_state     <= r_pull != 7'd0 ? STRIKE : AIM;
                        end
                    end
                end
                STRIKE: begin
                    if (startOfFrame) begin
                        r_pull <= w_dec;
                        if (w_dec == 7'd0) begin
                            r_state    <= FIRE;
                            shot_valid <= 1'b1;
                            shot_vx    <= (w_cos * w_sp) >>> 6;
                            shot_vy    <= (w_sin * w_sp) >>> 6;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cue_controller.sv
// tb_cue_controller: directed scenario tasks with hand-computed cue geometry and shot values.
module tb_cue_controller;
    logic clk = 1'b0;
    logic reset = 1'b1, sof = 1'b0, balls_moving = 1'b0;
    logic rotate_left = 1'b0, rotate_right = 1'b0, charge = 1'b0;
    logic signed [31:0] ball_x = 320, ball_y = 240;
    logic signed [31:0] close_x, close_y, far_x, far_y, shot_vx, shot_vy;
    logic cue_enable, shot_valid;
    logic [6:0] power;
    int n_checks = 0, n_fail = 0, shot_cnt = 0;
    always #5 clk = ~clk;
    cue_controller dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .ballX(ball_x), .ballY(ball_y),
        .balls_moving(balls_moving), .rotate_left(rotate_left), .rotate_right(rotate_right),
        .charge(charge), .closeEdgeX(close_x), .closeEdgeY(close_y), .farEdgeX(far_x),
        .farEdgeY(far_y), .cue_enable(cue_enable), .shot_valid(shot_valid),
        .shot_vx(shot_vx), .shot_vy(shot_vy), .power(power)
    );
    always @(negedge clk) if (shot_valid === 1'b1) shot_cnt++;
    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) sof = 1'b1;
            @(negedge clk) sof = 1'b0;
            @(negedge clk);
        end
    endtask
    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (close_x !== 0 || close_y !== 0) begin n_fail++; $display("FAIL reset_close got (%0d,%0d) exp (0,0)", close_x, close_y); end
        if (far_x !== 0 || far_y !== 0) begin n_fail++; $display("FAIL reset_far got (%0d,%0d) exp (0,0)", far_x, far_y); end
        if (cue_enable !== 1'b0) begin n_fail++; $display("FAIL reset_cue got %b exp 0", cue_enable); end
        if (shot_valid !== 1'b0) begin n_fail++; $display("FAIL reset_shot_valid got %b exp 0", shot_valid); end
        if (shot_vx !== 0 || shot_vy !== 0) begin n_fail++; $display("FAIL reset_shot_v got (%0d,%0d) exp (0,0)", shot_vx, shot_vy); end
        if (power !== 7'd0) begin n_fail++; $display("FAIL reset_power got %0d exp 0", power); end
        reset = 1'b0;
    endtask
    task automatic test_aim_entry;
        repeat (2) @(negedge clk);
        n_checks++;
        if (cue_enable !== 1'b0) begin n_fail++; $display("FAIL idle_cue got %b exp 0", cue_enable); end
        frame(1);
        n_checks += 3;
        if (cue_enable !== 1'b1) begin n_fail++; $display("FAIL aim_cue got %b exp 1", cue_enable); end
        if (close_x !== 300 || close_y !== 240) begin n_fail++; $display("FAIL aim_close got (%0d,%0d) exp (300,240)", close_x, close_y); end
        if (far_x !== 172 || far_y !== 240) begin n_fail++; $display("FAIL aim_far got (%0d,%0d) exp (172,240)", far_x, far_y); end
    endtask
    task automatic test_rotate;
        rotate_right = 1'b1;
        frame(3);
        n_checks++;
        if (close_x !== 300 || close_y !== 240) begin n_fail++; $display("FAIL rot_r3 got (%0d,%0d) exp (300,240)", close_x, close_y); end
        frame(1);
        rotate_right = 1'b0;
        n_checks += 2;
        if (close_x !== 301 || close_y !== 237) begin n_fail++; $display("FAIL rot_r4_close got (%0d,%0d) exp (301,237)", close_x, close_y); end
        if (far_x !== 175 || far_y !== 213) begin n_fail++; $display("FAIL rot_r4_far got (%0d,%0d) exp (175,213)", far_x, far_y); end
        rotate_left = 1'b1;
        frame(4);
        n_checks++;
        if (close_x !== 300 || close_y !== 240) begin n_fail++; $display("FAIL rot_back0 got (%0d,%0d) exp (300,240)", close_x, close_y); end
        frame(4);
        rotate_left = 1'b0;
        n_checks += 2;
        if (close_x !== 301 || close_y !== 244) begin n_fail++; $display("FAIL rot_wrap31_close got (%0d,%0d) exp (301,244)", close_x, close_y); end
        if (far_x !== 175 || far_y !== 268) begin n_fail++; $display("FAIL rot_wrap31_far got (%0d,%0d) exp (175,268)", far_x, far_y); end
        rotate_right = 1'b1;
        frame(4);
        n_checks++;
        if (close_x !== 300 || close_y !== 240) begin n_fail++; $display("FAIL rot_wrap0 got (%0d,%0d) exp (300,240)", close_x, close_y); end
        rotate_left = 1'b1;
        frame(8);
        rotate_left = 1'b0;
        rotate_right = 1'b0;
        n_checks++;
        if (close_x !== 300 || close_y !== 240) begin n_fail++; $display("FAIL rot_both got (%0d,%0d) exp (300,240)", close_x, close_y); end
    endtask
    task automatic test_charge;
        charge = 1'b1;
        frame(11);
        n_checks += 2;
        if (power !== 7'd10) begin n_fail++; $display("FAIL charge_ramp_power got %0d exp 10", power); end
        if (close_x !== 290) begin n_fail++; $display("FAIL charge_ramp_close got %0d exp 290", close_x); end
        frame(59);
        n_checks += 3;
        if (power !== 7'd64) begin n_fail++; $display("FAIL charge_sat_power got %0d exp 64", power); end
        if (close_x !== 236 || close_y !== 240) begin n_fail++; $display("FAIL charge_sat_close got (%0d,%0d) exp (236,240)", close_x, close_y); end
        if (far_x !== 108 || far_y !== 240) begin n_fail++; $display("FAIL charge_sat_far got (%0d,%0d) exp (108,240)", far_x, far_y); end
    endtask
    task automatic release_and_fire(input int evx, input int evy);
        int c0;
        c0 = shot_cnt;
        charge = 1'b0;
        frame(1);
        n_checks++;
        if (power !== 7'd64) begin n_fail++; $display("FAIL strike_start_power got %0d exp 64", power); end
        frame(7);
        n_checks += 3;
        if (power !== 7'd8) begin n_fail++; $display("FAIL strike7_power got %0d exp 8", power); end
        if (cue_enable !== 1'b1) begin n_fail++; $display("FAIL strike7_cue got %b exp 1", cue_enable); end
        if (shot_cnt !== c0) begin n_fail++; $display("FAIL strike7_early_shot got %0d exp %0d", shot_cnt, c0); end
        @(negedge clk) sof = 1'b1;
        @(negedge clk) sof = 1'b0;
        n_checks += 2;
        if (shot_valid !== 1'b1) begin n_fail++; $display("FAIL fire_valid got %b exp 1", shot_valid); end
        if (shot_vx !== evx || shot_vy !== evy) begin n_fail++; $display("FAIL fire_v got (%0d,%0d) exp (%0d,%0d)", shot_vx, shot_vy, evx, evy); end
        @(negedge clk);
        n_checks += 3;
        if (shot_valid !== 1'b0) begin n_fail++; $display("FAIL fire_one_cycle got %b exp 0", shot_valid); end
        if (cue_enable !== 1'b0) begin n_fail++; $display("FAIL fire_cue_off got %b exp 0", cue_enable); end
        if (shot_vx !== evx || shot_vy !== evy) begin n_fail++; $display("FAIL fire_hold got (%0d,%0d) exp (%0d,%0d)", shot_vx, shot_vy, evx, evy); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (shot_cnt !== c0 + 1) begin n_fail++; $display("FAIL fire_count got %0d exp %0d", shot_cnt, c0 + 1); end
    endtask
    task automatic test_strike_dir0;
        release_and_fire(64, 0);
    endtask
    task automatic test_strike_dir8;
        frame(1);
        rotate_right = 1'b1;
        frame(32);
        rotate_right = 1'b0;
        n_checks += 2;
        if (close_x !== 320 || close_y !== 220) begin n_fail++; $display("FAIL dir8_close got (%0d,%0d) exp (320,220)", close_x, close_y); end
        if (far_x !== 320 || far_y !== 92) begin n_fail++; $display("FAIL dir8_far got (%0d,%0d) exp (320,92)", far_x, far_y); end
        charge = 1'b1;
        frame(70);
        release_and_fire(0, 64);
    endtask
    task automatic test_charge_abort;
        int c0;
        c0 = shot_cnt;
        frame(1);
        charge = 1'b1;
        frame(1);
        charge = 1'b0;
        frame(1);
        n_checks += 2;
        if (cue_enable !== 1'b1) begin n_fail++; $display("FAIL zero_pull_aim_cue got %b exp 1", cue_enable); end
        if (power !== 7'd0) begin n_fail++; $display("FAIL zero_pull_power got %0d exp 0", power); end
        charge = 1'b1;
        frame(4);
        n_checks++;
        if (power !== 7'd3) begin n_fail++; $display("FAIL abort_pre_power got %0d exp 3", power); end
        balls_moving = 1'b1;
        repeat (3) @(negedge clk);
        charge = 1'b0;
        n_checks += 3;
        if (cue_enable !== 1'b0) begin n_fail++; $display("FAIL abort_cue got %b exp 0", cue_enable); end
        if (power !== 7'd0) begin n_fail++; $display("FAIL abort_power got %0d exp 0", power); end
        if (shot_cnt !== c0) begin n_fail++; $display("FAIL abort_no_shot got %0d exp %0d", shot_cnt, c0); end
        balls_moving = 1'b0;
    endtask
    task automatic test_reset_strike;
        int c0;
        c0 = shot_cnt;
        frame(1);
        charge = 1'b1;
        frame(10);
        charge = 1'b0;
        frame(2);
        n_checks++;
        if (power !== 7'd1) begin n_fail++; $display("FAIL mid_strike_power got %0d exp 1", power); end
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        n_checks += 5;
        if (close_x !== 0 || close_y !== 0 || far_x !== 0 || far_y !== 0) begin n_fail++; $display("FAIL rst_strike_edges got (%0d,%0d,%0d,%0d) exp zeros", close_x, close_y, far_x, far_y); end
        if (cue_enable !== 1'b0) begin n_fail++; $display("FAIL rst_strike_cue got %b exp 0", cue_enable); end
        if (power !== 7'd0) begin n_fail++; $display("FAIL rst_strike_power got %0d exp 0", power); end
        if (shot_valid !== 1'b0) begin n_fail++; $display("FAIL rst_strike_valid got %b exp 0", shot_valid); end
        if (shot_vx !== 0 || shot_vy !== 0) begin n_fail++; $display("FAIL rst_strike_v got (%0d,%0d) exp (0,0)", shot_vx, shot_vy); end
        @(negedge clk) reset = 1'b0;
        frame(4);
        n_checks += 3;
        if (shot_cnt !== c0) begin n_fail++; $display("FAIL rst_strike_no_shot got %0d exp %0d", shot_cnt, c0); end
        if (close_x !== 300 || close_y !== 240) begin n_fail++; $display("FAIL rst_dir0_close got (%0d,%0d) exp (300,240)", close_x, close_y); end
        if (power !== 7'd0) begin n_fail++; $display("FAIL rst_after_power got %0d exp 0", power); end
    endtask
    initial begin
        test_reset;
        test_aim_entry;
        test_rotate;
        test_charge;
        test_strike_dir0;
        test_strike_dir8;
        test_charge_abort;
        test_reset_strike;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
